// File: rtl/maze_solve_sched.sv
// Round-robin scheduler sharing one maze solver between NREQ requesters:
// grants a requester, sequences the solver reset, counts moves and returns one result per job.
module maze_solve_sched #(
  parameter int NREQ    = 2,
  parameter int N       = 3,
  parameter int CW      = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   maze_sel,
  output logic                      solver_rst,
  input  logic                      solver_done,
  input  logic [N-1:0]              solver_x,
  input  logic [N-1:0]              solver_y,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [CW-1:0]             res_steps,
  output logic                      res_timeout,
  output logic                      busy
);

  localparam int SW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

  state_t        state, state_n;
  logic [SW-1:0] ptr;
  logic [CW-1:0] cyc_cnt, step_cnt, step_nxt;
  logic [N-1:0]  px, py;
  logic          move, run_end;
  logic          pick_valid;
  logic [SW-1:0] pick_idx;
  logic [SW:0]   scan_sum;

  // Scan downward in offset so the closest requester after ptr is the one that sticks.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      scan_sum = {1'b0, ptr} + (SW+1)'(i);
      if (scan_sum >= (SW+1)'(NREQ))
        scan_sum = scan_sum - (SW+1)'(NREQ);
      if (req[scan_sum[SW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_sum[SW-1:0];
      end
    end
  end

  assign move     = {solver_x, solver_y} != {px, py};
  assign step_nxt = (move && step_cnt != '1) ? step_cnt + 1'b1 : step_cnt;
  assign run_end  = solver_done || (cyc_cnt == CW'(TIMEOUT-1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_valid) state_n = LAUNCH;
      LAUNCH:  state_n = RUN;
      RUN:     if (run_end) state_n = REPORT;
      REPORT:  if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= SW'(NREQ-1);
      gnt         <= '0;
      maze_sel    <= '0;
      solver_rst  <= 1'b1;
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_steps   <= '0;
      res_timeout <= 1'b0;
      cyc_cnt     <= '0;
      step_cnt    <= '0;
      px          <= '0;
      py          <= '0;
    end else begin
      state      <= state_n;
      solver_rst <= (state_n != RUN);
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt      <= NREQ'(1) << pick_idx;
            maze_sel <= pick_idx;
          end
        end
        LAUNCH: begin
          cyc_cnt  <= '0;
          step_cnt <= '0;
          px       <= '0;
          py       <= '0;
        end
        RUN: begin
          cyc_cnt  <= cyc_cnt + 1'b1;
          step_cnt <= step_nxt;
          if (move) begin
            px <= solver_x;
            py <= solver_y;
          end
          // A move in the finishing cycle is still counted; done beats the watchdog.
          if (run_end) begin
            res_valid   <= 1'b1;
            res_id      <= maze_sel;
            res_steps   <= step_nxt;
            res_timeout <= !solver_done;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ptr       <= maze_sel;
            gnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_solve_sched.sv
// Directed bench for maze_solve_sched: table of jobs plus a hand-written reset-mid-RUN sequence.
module tb_maze_solve_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       maze_sel;
  logic       solver_rst;
  logic       solver_done;
  logic [2:0] solver_x, solver_y;
  logic       res_valid;
  logic       res_ready;
  logic       res_id;
  logic [7:0] res_steps;
  logic       res_timeout;
  logic       busy;

  int checkCount = 0;
  int passCount  = 0;

  maze_solve_sched #(.NREQ(2), .N(3), .CW(8), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .maze_sel(maze_sel),
    .solver_rst(solver_rst), .solver_done(solver_done),
    .solver_x(solver_x), .solver_y(solver_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_steps(res_steps), .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] reqStart;
    logic [1:0] reqRun;
    int         doneAt;
    int         mode;
    int         readyDelay;
    logic [1:0] expGnt;
    int         expId;
    int         expSteps;
    logic       expTmo;
    int         expRun;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passCount++;
  endtask

  // mode 0: (1,0),(1,0),(1,1)...; mode 1: new position every cycle; mode 2: parked at origin
  function automatic logic [5:0] solverPos(input int mode, input int c);
    logic [2:0] cx;
    cx = 3'(c);
    case (mode)
      0:       return (c <= 2) ? {3'd1, 3'd0} : {3'd1, 3'd1};
      1:       return {cx, 3'd0};
      default: return 6'd0;
    endcase
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    int c;
    req = v.reqStart;
    @(posedge clk); #1;
    checkOutput({tag, " grant"}, 32'(gnt), 32'(v.expGnt));
    checkOutput({tag, " maze_sel"}, 32'(maze_sel), 32'(v.expId));
    checkOutput({tag, " launch solver_rst"}, 32'(solver_rst), 32'd1);
    checkOutput({tag, " launch busy"}, 32'(busy), 32'd1);
    req = v.reqRun;
    @(posedge clk); #1;
    checkOutput({tag, " run solver_rst"}, 32'(solver_rst), 32'd0);
    c = 0;
    while (1) begin
      c++;
      solver_done = (c == v.doneAt);
      {solver_x, solver_y} = solverPos(v.mode, c);
      @(posedge clk); #1;
      if (res_valid === 1'b1) break;
      checkOutput({tag, " run solver_rst"}, 32'(solver_rst), 32'd0);
      if (c >= 250) begin
        checkOutput({tag, " result timeout"}, 32'(res_valid), 32'd1);
        solver_done = 1'b0;
        return;
      end
    end
    solver_done = 1'b0;
    {solver_x, solver_y} = 6'd0;
    checkOutput({tag, " run_cycles"}, 32'(c), 32'(v.expRun));
    checkOutput({tag, " res_id"}, 32'(res_id), 32'(v.expId));
    checkOutput({tag, " res_steps"}, 32'(res_steps), 32'(v.expSteps));
    checkOutput({tag, " res_timeout"}, 32'(res_timeout), 32'(v.expTmo));
    checkOutput({tag, " report solver_rst"}, 32'(solver_rst), 32'd1);
    for (int d = 0; d < v.readyDelay; d++) begin
      @(posedge clk); #1;
      checkOutput({tag, " hold res_valid"}, 32'(res_valid), 32'd1);
      checkOutput({tag, " hold res_id"}, 32'(res_id), 32'(v.expId));
      checkOutput({tag, " hold res_steps"}, 32'(res_steps), 32'(v.expSteps));
      checkOutput({tag, " hold res_timeout"}, 32'(res_timeout), 32'(v.expTmo));
      checkOutput({tag, " hold gnt"}, 32'(gnt), 32'(v.expGnt));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " idle gnt"}, 32'(gnt), 32'd0);
    checkOutput({tag, " idle res_valid"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    vec_t fin;
    // reqStart reqRun doneAt mode delay expGnt expId steps tmo run
    vecs[0] = '{2'b11, 2'b11, 3, 2, 0, 2'b01, 0,  0, 1'b0, 3};
    vecs[1] = '{2'b11, 2'b11, 3, 2, 0, 2'b10, 1,  0, 1'b0, 3};
    vecs[2] = '{2'b11, 2'b11, 3, 2, 0, 2'b01, 0,  0, 1'b0, 3};
    vecs[3] = '{2'b11, 2'b11, 3, 2, 0, 2'b10, 1,  0, 1'b0, 3};
    vecs[4] = '{2'b01, 2'b01, 5, 0, 0, 2'b01, 0,  2, 1'b0, 5};
    vecs[5] = '{2'b10, 2'b10, 0, 1, 0, 2'b10, 1, 10, 1'b1, 10};
    vecs[6] = '{2'b01, 2'b10, 2, 2, 7, 2'b01, 0,  0, 1'b0, 2};

    rst = 1'b0; req = 2'b00; solver_done = 1'b0;
    solver_x = 3'd0; solver_y = 3'd0; res_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset gnt", 32'(gnt), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset solver_rst", 32'(solver_rst), 32'd1);
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset res_steps", 32'(res_steps), 32'd0);
    checkOutput("reset res_id", 32'(res_id), 32'd0);
    checkOutput("reset maze_sel", 32'(maze_sel), 32'd0);
    checkOutput("reset res_timeout", 32'(res_timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i], $sformatf("job%0d", i));

    // Requester 1 was left pending during the backpressured job and gets the next grant.
    req = 2'b10;
    @(posedge clk); #1;
    checkOutput("post-backpressure gnt", 32'(gnt), 32'b10);
    @(posedge clk); #1;
    checkOutput("rst-job run solver_rst", 32'(solver_rst), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checkOutput("mid-run reset gnt", 32'(gnt), 32'd0);
    checkOutput("mid-run reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("mid-run reset solver_rst", 32'(solver_rst), 32'd1);
    checkOutput("mid-run reset busy", 32'(busy), 32'd0);

    // Priority restarts at requester 0; this job also hits done on the watchdog cycle.
    fin = '{2'b11, 2'b11, 10, 1, 0, 2'b01, 0, 10, 1'b0, 10};
    applyStimulus(fin, "collision");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/maze_solve_sched.md
# maze_solve_sched

Round-robin job scheduler that shares one `mazeEscaper` solver instance between `NREQ` maze requesters. It grants one requester at a time and drives the maze mux select. It sequences the solver's reset, watches for completion or a watchdog timeout, counts solver moves, and returns one result per job over a valid/ready handshake. The block sits between the requester ports and the solver; maze data and path bits are muxed outside it using `maze_sel`.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `N`, 3: solver coordinate width; matches solver `N`.
- `CW`, 8: width of the cycle and step counters.
- `TIMEOUT`, 200: RUN cycles allowed before abort; must be < 2^CW.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req` in NREQ: level request per requester.
- `gnt` out NREQ: one-hot grant, held for the whole job.
- `maze_sel` out $clog2(NREQ): index of the granted requester.
- `solver_rst` out 1: active-high reset to the solver.
- `solver_done` in 1: solver `done`.
- `solver_x` in N: solver x.
- `solver_y` in N: solver y.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer accept.
- `res_id` out $clog2(NREQ): requester index of the result.
- `res_steps` out CW: counted solver moves, saturating.
- `res_timeout` out 1: job aborted by watchdog.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LAUNCH, RUN, REPORT.
- **IDLE:**
  - `solver_rst`=1.
  - If `req` != 0, select the first set bit searching upward from `ptr+1` (mod NREQ).
  - Register `gnt` and `maze_sel`, go to LAUNCH.
  - Otherwise stay in IDLE.
- **LAUNCH (1 cycle):**
  - `solver_rst`=1 with `maze_sel` stable.
  - Clear `cyc_cnt` and `step_cnt`.
  - Load `{px,py}` = `{0,0}` (the solver's post-reset position).
  - Go to RUN.
- **RUN:**
  - `solver_rst`=0.
  - Each cycle: `cyc_cnt`++.
  - If `{solver_x,solver_y}` != `{px,py}`: `step_cnt`++ (saturate at 2^CW-1) and update `{px,py}`.
  - If `solver_done`=1: latch results with `res_timeout`=0, go to REPORT.
  - Else if `cyc_cnt` == TIMEOUT-1: latch results with `res_timeout`=1, go to REPORT.
  - `solver_done` takes priority when both happen in the same cycle.
  - A move seen in the same cycle as `solver_done` is still counted.
- **REPORT:**
  - `solver_rst`=1.
  - `res_valid`=1.
  - `res_id`, `res_steps`, `res_timeout` held stable until `res_valid`&&`res_ready`.
  - On handshake: `ptr` <= `maze_sel`, `gnt` <= 0, go to IDLE.
- **req behaviour:**
  - Deasserting `req` during a job does not cancel it; the result is still reported.
  - A requester whose `req` is still high after its job is re-eligible only in round-robin order.
- `gnt` is one-hot or zero at all times; `gnt`[`maze_sel`]=1 whenever `busy`=1.
- Reset values: state=IDLE, `ptr`=NREQ-1 (so requester 0 has first priority), `gnt`=0, `maze_sel`=0, `solver_rst`=1, `res_valid`=0, `res_id`=0, `res_steps`=0, `res_timeout`=0, `busy`=0, counters=0.
- Reset mid-job: the next edge with `rst`=0 forces all reset values. Any pending result is discarded and the solver is held in reset.

## Timing
- `req` seen in IDLE at edge t:
  - `gnt`/`busy` high after t.
  - LAUNCH during cycle t+1; RUN from t+2.
- `solver_done` (or the timeout condition) sampled at RUN edge k: `res_valid`=1 from k+1.
- Handshake at edge h: IDLE from h+1. The earliest next grant is registered at edge h+1, giving a minimum 1 IDLE cycle between jobs.
- Timeout job: exactly TIMEOUT RUN cycles, then REPORT.
- `res_valid` is never deasserted without a handshake (except by reset).
- Outputs are all registered except `busy`, which is decoded from state.

## Test plan
- **Single job:** NREQ=2, `req`=01. Solver model moves (0,0)->(1,0)->(1,1) then `done` on RUN cycle 5. Required: `gnt`=01, `solver_rst` low for 5 RUN cycles, `res_id`=0, `res_steps`=2, `res_timeout`=0, `res_valid` 1 cycle after `done`.
- **Round-robin:** `req`=11 held, every job `done` after 3 cycles, `res_ready`=1. Required grant order 0,1,0,1 with exactly one IDLE cycle between jobs.
- **Timeout:** TIMEOUT=10, `solver_done` stuck 0, position changes every cycle. Required: REPORT after exactly 10 RUN cycles, `res_timeout`=1, `res_steps`=10.
- **Backpressure:** `res_ready`=0 for 7 cycles after `res_valid`, with `req`=10 pending. Required: result fields stable, `gnt` unchanged, no new grant until the handshake, then `gnt`=10.
- **Done/timeout collision:** `solver_done` rises on the cycle where `cyc_cnt`=TIMEOUT-1. Required: `res_timeout`=0.
- **Reset mid-RUN:** `rst`=0 for one edge during RUN. Required: next cycle `gnt`=0, `res_valid`=0, `solver_rst`=1, `busy`=0. With `req`=11, the next grant goes to requester 0.
